sram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one multi-channel port of `sram_dp` among `NUM_REQ` requesters, such as the DMA loader, the weight fetcher and the result writer. It accepts at most one request per cycle and drives registered SRAM port controls. It also tracks outstanding reads, so each read response is returned only to the requester that issued it. An optional bounded lock lets one requester issue back-to-back bursts.

---
 rtl/sram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter with bounded lock that shares one sram_dp
// port among NUM_REQ requesters and routes each read response back to its issuer.
module sram_port_arbiter #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ADDRW              = 12,
  parameter int unsigned MAX_CHANNELS       = 64,
  parameter int unsigned NUM_CHANNELS_WIDTH = 7,
  parameter int unsigned NUM_REQ            = 4,
  parameter int unsigned MAX_LOCK           = 16
) (
  input  logic                                        clk_i,
  input  logic                                        rst_n_i,
  input  logic [NUM_REQ-1:0]                          req_i,
  input  logic [NUM_REQ-1:0]                          we_i,
  input  logic [NUM_REQ-1:0]                          lock_i,
  input  logic [NUM_REQ*NUM_CHANNELS_WIDTH-1:0]       num_channels_i,
  input  logic [NUM_REQ*ADDRW*MAX_CHANNELS-1:0]       addr_i,
  input  logic [NUM_REQ*DATA_WIDTH*MAX_CHANNELS-1:0]  data_i,
  output logic [NUM_REQ-1:0]                          gnt_o,
  output logic [NUM_REQ-1:0]                          rvalid_o,
  output logic [DATA_WIDTH*MAX_CHANNELS-1:0]          rdata_o,
  output logic                                        err_o,
  output logic                                        sram_en_o,
  output logic                                        sram_we_o,
  output logic [NUM_CHANNELS_WIDTH-1:0]               sram_num_channels_o,
  output logic [ADDRW*MAX_CHANNELS-1:0]               sram_addr_o,
  output logic [DATA_WIDTH*MAX_CHANNELS-1:0]          sram_data_o,
  input  logic [DATA_WIDTH*MAX_CHANNELS-1:0]          sram_data_i,
  input  logic                                        sram_ready_i
);

  localparam int unsigned IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LCW  = $clog2(MAX_LOCK + 1);
  localparam int unsigned NCW  = NUM_CHANNELS_WIDTH;
  localparam int unsigned AW   = ADDRW * MAX_CHANNELS;
  localparam int unsigned DW   = DATA_WIDTH * MAX_CHANNELS;

  // arbitration state
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] prev_idx_q, prev_idx_d;
  logic            lock_hold_q, lock_hold_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;

  // two-entry owner FIFO of outstanding reads
  logic [IDXW-1:0] fifo_mem_q [2];
  logic            fifo_wr_q;
  logic            fifo_rd_q;
  logic [1:0]      fifo_cnt_q;

  // registered SRAM port and sticky error
  logic            err_q;
  logic            sram_en_q;
  logic            sram_we_q;
  logic [NCW-1:0]  sram_nc_q;
  logic [AW-1:0]   sram_addr_q;
  logic [DW-1:0]   sram_data_q;

  logic               fifo_full_c;
  logic               fifo_push_c;
  logic               fifo_pop_c;
  logic [NUM_REQ-1:0] elig_c;
  logic [NUM_REQ-1:0] others_c;
  logic               gnt_vld_c;
  logic               locked_c;
  logic [IDXW-1:0]    win_c;
  logic [IDXW-1:0]    cand_c;
  logic [NCW-1:0]     win_nc_c;
  logic               win_we_c;
  logic               win_lock_c;
  logic               illegal_c;
  logic               issue_c;

  assign fifo_full_c = (fifo_cnt_q == 2'd2);
  assign elig_c      = req_i & (we_i | {NUM_REQ{~fifo_full_c}});

  // winner selection: locked re-grant first, otherwise first eligible from rr_ptr
  always_comb begin
    gnt_vld_c = 1'b0;
    locked_c  = 1'b0;
    win_c     = '0;
    cand_c    = '0;
    others_c  = elig_c & ~(NUM_REQ'(1) << prev_idx_q);
    if (lock_hold_q && elig_c[prev_idx_q] &&
        ((lock_cnt_q < LCW'(MAX_LOCK)) || (others_c == '0))) begin
      gnt_vld_c = 1'b1;
      locked_c  = 1'b1;
      win_c     = prev_idx_q;
    end else begin
      // scan from the far end so the nearest eligible index overrides
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
        cand_c = IDXW'((int'(rr_ptr_q) + i) % int'(NUM_REQ));
        if (elig_c[cand_c]) begin
          gnt_vld_c = 1'b1;
          win_c     = cand_c;
        end
      end
    end
  end

  assign win_we_c    = we_i[win_c];
  assign win_lock_c  = lock_i[win_c];
  assign win_nc_c    = num_channels_i[win_c*NCW +: NCW];
  assign illegal_c   = (win_nc_c == '0) || (win_nc_c > NCW'(MAX_CHANNELS));
  assign issue_c     = gnt_vld_c && !illegal_c;
  assign fifo_push_c = issue_c && !win_we_c;
  assign fifo_pop_c  = sram_ready_i && (fifo_cnt_q != 2'd0);

  assign gnt_o    = gnt_vld_c ? (NUM_REQ'(1) << win_c) : '0;
  assign rvalid_o = fifo_pop_c ? (NUM_REQ'(1) << fifo_mem_q[fifo_rd_q]) : '0;
  assign rdata_o  = fifo_pop_c ? sram_data_i : '0;

  assign err_o               = err_q;
  assign sram_en_o           = sram_en_q;
  assign sram_we_o           = sram_we_q;
  assign sram_num_channels_o = sram_nc_q;
  assign sram_addr_o         = sram_addr_q;
  assign sram_data_o         = sram_data_q;

  // next round-robin pointer and lock bookkeeping
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    prev_idx_d  = prev_idx_q;
    lock_hold_d = 1'b0;
    lock_cnt_d  = '0;
    if (gnt_vld_c) begin
      rr_ptr_d    = IDXW'((int'(win_c) + 1) % int'(NUM_REQ));
      prev_idx_d  = win_c;
      lock_hold_d = win_lock_c;
      if (locked_c && win_lock_c) begin
        lock_cnt_d = (lock_cnt_q < LCW'(MAX_LOCK)) ? lock_cnt_q + LCW'(1) : lock_cnt_q;
      end
    end
  end

  // arbitration state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q    <= '0;
      prev_idx_q  <= '0;
      lock_hold_q <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      prev_idx_q  <= prev_idx_d;
      lock_hold_q <= lock_hold_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  // owner FIFO: push granted read index, pop on each SRAM read response
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      if (fifo_push_c) begin
        fifo_mem_q[fifo_wr_q] <= win_c;
        fifo_wr_q             <= ~fifo_wr_q;
      end
      if (fifo_pop_c) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
      fifo_cnt_q <= fifo_cnt_q + 2'(fifo_push_c) - 2'(fifo_pop_c);
    end
  end

  // SRAM port registers; payload holds when nothing legal is issued
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q       <= 1'b0;
      sram_en_q   <= 1'b0;
      sram_we_q   <= 1'b0;
      sram_nc_q   <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
    end else begin
      err_q     <= err_q | (gnt_vld_c & illegal_c);
      sram_en_q <= issue_c;
      sram_we_q <= issue_c & win_we_c;
      if (issue_c) begin
        sram_nc_q   <= win_nc_c;
        sram_addr_q <= addr_i[win_c*AW +: AW];
        sram_data_q <= data_i[win_c*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random stimulus against a queue-based reference
// model plus a behavioural SRAM that answers the DUT's port.
module tb_sram_port_arbiter;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned ADDRW        = 12;
  localparam int unsigned MAX_CHANNELS = 64;
  localparam int unsigned NCW          = 7;
  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned MAX_LOCK     = 16;
  localparam int unsigned AW           = ADDRW * MAX_CHANNELS;
  localparam int unsigned DW           = DATA_WIDTH * MAX_CHANNELS;

  logic                               clk_i = 1'b0;
  logic                               rst_n_i;
  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0]                 we_i;
  logic [NUM_REQ-1:0]                 lock_i;
  logic [NUM_REQ*NCW-1:0]             num_channels_i;
  logic [NUM_REQ*AW-1:0]              addr_i;
  logic [NUM_REQ*DW-1:0]              data_i;
  logic [NUM_REQ-1:0]                 gnt_o;
  logic [NUM_REQ-1:0]                 rvalid_o;
  logic [DW-1:0]                      rdata_o;
  logic                               err_o;
  logic                               sram_en_o;
  logic                               sram_we_o;
  logic [NCW-1:0]                     sram_num_channels_o;
  logic [AW-1:0]                      sram_addr_o;
  logic [DW-1:0]                      sram_data_o;
  logic [DW-1:0]                      sram_data_i;
  logic                               sram_ready_i;

  sram_port_arbiter #(
    .DATA_WIDTH(DATA_WIDTH), .ADDRW(ADDRW), .MAX_CHANNELS(MAX_CHANNELS),
    .NUM_CHANNELS_WIDTH(NCW), .NUM_REQ(NUM_REQ), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
    .num_channels_i(num_channels_i), .addr_i(addr_i), .data_i(data_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .sram_en_o(sram_en_o), .sram_we_o(sram_we_o),
    .sram_num_channels_o(sram_num_channels_o), .sram_addr_o(sram_addr_o),
    .sram_data_o(sram_data_o), .sram_data_i(sram_data_i), .sram_ready_i(sram_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // reference model state
  int               m_rr;
  int               m_last;
  bit               m_last_lock;
  int               m_streak;
  int               m_own[$];
  logic [DW-1:0]    m_rd[$];
  bit               m_err;
  logic [7:0]       ref_mem [4096];
  bit               e_en;
  bit               e_we;
  logic [NCW-1:0]   e_nc;
  logic [AW-1:0]    e_addr;
  logic [DW-1:0]    e_data;

  // behavioural SRAM on the DUT side
  logic [7:0]       env_mem [4096];
  int               env_due[$];
  logic [DW-1:0]    env_dat[$];
  int               delay_mode;
  bit               stray_en;
  int               cyc;
  logic [NUM_REQ-1:0] last_gnt;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic set_req(input int k, input bit r, input bit w, input bit l, input int nc,
                         input int abase, input int dbase, input int dstep);
    req_i[k]  = r;
    we_i[k]   = w;
    lock_i[k] = l;
    num_channels_i[k*NCW +: NCW] = NCW'(nc);
    for (int ch = 0; ch < int'(MAX_CHANNELS); ch++) begin
      addr_i[(k*MAX_CHANNELS+ch)*ADDRW +: ADDRW]           = ADDRW'(abase + ch);
      data_i[(k*MAX_CHANNELS+ch)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(dbase + ch*dstep);
    end
  endtask

  task automatic set_rand(input int k);
    int nc;
    req_i[k]  = ($urandom_range(0, 9) < 6);
    we_i[k]   = $urandom_range(0, 1) == 1;
    lock_i[k] = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 39) == 0) nc = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 127);
    else nc = $urandom_range(1, 64);
    num_channels_i[k*NCW +: NCW] = NCW'(nc);
    for (int ch = 0; ch < int'(MAX_CHANNELS); ch++) begin
      addr_i[(k*MAX_CHANNELS+ch)*ADDRW +: ADDRW]           = ADDRW'($urandom_range(0, 63));
      data_i[(k*MAX_CHANNELS+ch)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
    end
  endtask

  task automatic clear_reqs();
    req_i  = '0;
    we_i   = '0;
    lock_i = '0;
  endtask

  task automatic model_reset();
    m_rr = 0; m_last = -1; m_last_lock = 0; m_streak = 0; m_err = 0;
    m_own.delete(); m_rd.delete();
    e_en = 0; e_we = 0; e_nc = '0; e_addr = '0; e_data = '0;
  endtask

  // one clock cycle: SRAM answer, checks at the falling edge, then model update
  task automatic cycle();
    bit               el[NUM_REQ];
    bit               any_other;
    bit               locked;
    bit               legal;
    int               win;
    int               k;
    int               nc;
    int               own;
    int               due;
    logic [NUM_REQ-1:0] exp_gnt;
    logic [NUM_REQ-1:0] exp_rv;
    logic [DW-1:0]    exp_rdata;
    logic [DW-1:0]    v;
    logic [AW-1:0]    a;
    logic [DW-1:0]    d;

    if (env_due.size() > 0 && env_due[0] == cyc) begin
      sram_ready_i = 1'b1;
      sram_data_i  = env_dat.pop_front();
      void'(env_due.pop_front());
    end else if (stray_en && m_own.size() == 0 && $urandom_range(0, 3) == 0) begin
      sram_ready_i = 1'b1;
      sram_data_i  = rand_vec();
    end else begin
      sram_ready_i = 1'b0;
      sram_data_i  = rand_vec();
    end

    @(negedge clk_i);
    last_gnt = gnt_o;

    if (!rst_n_i) begin
      model_reset();
      chk("rst_gnt", AW'(gnt_o), '0);
      chk("rst_rvalid", AW'(rvalid_o), '0);
      chk("rst_rdata", AW'(rdata_o), '0);
      chk("rst_err", AW'(err_o), '0);
      chk("rst_en", AW'(sram_en_o), '0);
      chk("rst_we", AW'(sram_we_o), '0);
      chk("rst_nc", AW'(sram_num_channels_o), '0);
      chk("rst_addr", sram_addr_o, '0);
      chk("rst_data", AW'(sram_data_o), '0);
      rst_n_i = 1'b1;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++)
        el[i] = req_i[i] && (we_i[i] || m_own.size() < 2);
      any_other = 0;
      for (int i = 0; i < int'(NUM_REQ); i++)
        if (i != m_last && el[i]) any_other = 1;
      win = -1;
      locked = 0;
      if (m_last >= 0 && m_last_lock && el[m_last] &&
          (m_streak < int'(MAX_LOCK) || !any_other)) begin
        win = m_last;
        locked = 1;
      end else begin
        for (int j = 0; j < int'(NUM_REQ); j++) begin
          k = (m_rr + j) % int'(NUM_REQ);
          if (win < 0 && el[k]) win = k;
        end
      end
      exp_gnt = (win >= 0) ? (NUM_REQ'(1) << win) : '0;
      chk("gnt", AW'(gnt_o), AW'(exp_gnt));

      exp_rv = '0;
      exp_rdata = '0;
      if (sram_ready_i && m_own.size() > 0) begin
        own = m_own.pop_front();
        exp_rv = NUM_REQ'(1) << own;
        exp_rdata = m_rd.pop_front();
      end
      chk("rvalid", AW'(rvalid_o), AW'(exp_rv));
      chk("rdata", AW'(rdata_o), AW'(exp_rdata));
      chk("sram_en", AW'(sram_en_o), AW'(e_en));
      chk("sram_we", AW'(sram_we_o), AW'(e_we));
      chk("sram_nc", AW'(sram_num_channels_o), AW'(e_nc));
      chk("sram_addr", sram_addr_o, e_addr);
      chk("sram_data", AW'(sram_data_o), AW'(e_data));
      chk("err", AW'(err_o), AW'(m_err));

      if (win >= 0) begin
        nc = int'(num_channels_i[win*NCW +: NCW]);
        legal = (nc >= 1) && (nc <= int'(MAX_CHANNELS));
        if (!legal) m_err = 1;
        if (legal) begin
          a = addr_i[win*AW +: AW];
          d = data_i[win*DW +: DW];
          e_en = 1; e_we = we_i[win]; e_nc = NCW'(nc); e_addr = a; e_data = d;
          if (we_i[win]) begin
            for (int ch = 0; ch < nc; ch++) ref_mem[a[ch*ADDRW +: ADDRW]] = d[ch*8 +: 8];
          end else begin
            v = '0;
            for (int ch = 0; ch < nc; ch++) v[ch*8 +: 8] = ref_mem[a[ch*ADDRW +: ADDRW]];
            m_own.push_back(win);
            m_rd.push_back(v);
          end
        end else begin
          e_en = 0;
          e_we = 0;
        end
        if (locked && lock_i[win]) m_streak = (m_streak < int'(MAX_LOCK)) ? m_streak + 1 : m_streak;
        else m_streak = 0;
        m_last = win;
        m_last_lock = lock_i[win];
        m_rr = (win + 1) % int'(NUM_REQ);
      end else begin
        e_en = 0;
        e_we = 0;
        m_streak = 0;
        m_last_lock = 0;
      end
    end

    // SRAM side reacts to what the DUT actually issued
    if (sram_en_o === 1'b1) begin
      nc = int'(sram_num_channels_o);
      if (sram_we_o) begin
        for (int ch = 0; ch < nc; ch++)
          env_mem[sram_addr_o[ch*ADDRW +: ADDRW]] = sram_data_o[ch*8 +: 8];
      end else begin
        v = '0;
        for (int ch = 0; ch < nc; ch++) v[ch*8 +: 8] = env_mem[sram_addr_o[ch*ADDRW +: ADDRW]];
        due = cyc + ((delay_mode == 0) ? int'($urandom_range(1, 2)) : delay_mode);
        if (env_due.size() > 0 && due <= env_due[$]) due = env_due[$] + 1;
        env_due.push_back(due);
        env_dat.push_back(v);
      end
    end

    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  int run;
  bit counting;
  logic [NUM_REQ-1:0] after;
  bit saw_wr;

  initial begin
    rst_n_i = 1'b1;
    clear_reqs();
    num_channels_i = '0;
    addr_i = '0;
    data_i = '0;
    sram_ready_i = 1'b0;
    sram_data_i = '0;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 8'h00;
      env_mem[i] = 8'h00;
    end
    cyc = 0;
    delay_mode = 1;
    stray_en = 0;
    last_gnt = '0;
    model_reset();
    #1 rst_n_i = 1'b0;
    cycle();

    // single requester write then read-back
    set_req(0, 1, 1, 0, 4, 0, 8'h11, 8'h11);
    cycle();
    clear_reqs();
    cycle();
    set_req(0, 1, 0, 0, 4, 0, 0, 0);
    cycle();
    clear_reqs();
    repeat (4) cycle();

    // fairness: preload each requester's region, then all read together
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      clear_reqs();
      set_req(k, 1, 1, 0, 8, k*64, k*16 + 1, 3);
      cycle();
    end
    clear_reqs();
    cycle();
    for (int k = 0; k < int'(NUM_REQ); k++) set_req(k, 1, 0, 0, 8, k*64, 0, 0);
    repeat (16) cycle();
    clear_reqs();
    repeat (4) cycle();

    // lock: req1 alone first, then req2 competes
    set_req(1, 1, 1, 1, 4, 100, 5, 1);
    cycle();
    run = (last_gnt == 4'b0010) ? 1 : 0;
    counting = 1;
    after = '0;
    set_req(2, 1, 1, 0, 4, 200, 9, 1);
    repeat (22) begin
      cycle();
      if (counting && last_gnt == 4'b0010) run++;
      else if (counting) begin
        counting = 0;
        after = last_gnt;
      end
    end
    chk("lock_run", AW'(run), AW'(17));
    chk("lock_next", AW'(after), AW'(4'b0100));
    clear_reqs();
    repeat (2) cycle();

    // FIFO full: slow responses, three readers and one writer
    delay_mode = 2;
    saw_wr = 0;
    for (int k = 0; k < 3; k++) set_req(k, 1, 0, 0, 8, k*64, 0, 0);
    set_req(3, 1, 1, 0, 2, 300, 7, 1);
    repeat (14) begin
      cycle();
      if (last_gnt == 4'b1000) saw_wr = 1;
    end
    chk("fifo_wr_gnt", AW'(saw_wr), AW'(1));
    clear_reqs();
    repeat (5) cycle();

    // illegal requests: zero channels and too many channels
    set_req(3, 1, 0, 0, 0, 0, 0, 0);
    cycle();
    clear_reqs();
    repeat (3) cycle();
    set_req(0, 1, 1, 0, 65, 0, 0, 0);
    cycle();
    clear_reqs();
    repeat (3) cycle();

    // reset between read grant and its response
    set_req(0, 1, 0, 0, 4, 0, 0, 0);
    cycle();
    clear_reqs();
    cycle();
    rst_n_i = 1'b0;
    cycle();
    repeat (3) cycle();

    // random traffic with random latency and stray responses
    delay_mode = 0;
    stray_en = 1;
    repeat (400) begin
      for (int k = 0; k < int'(NUM_REQ); k++) set_rand(k);
      cycle();
    end
    clear_reqs();
    stray_en = 0;
    repeat (6) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
